// File: rtl/conv2d_pkg.sv
// conv2d_mem_core shared definitions: dimensions, address widths, states.
// Imported by conv2d_tap_gen and conv2d_mem_core.
package conv2d_pkg;
  localparam int WIDTH_D    = 32;
  localparam int HEIGHT_D   = 32;
  localparam int CHANNELS_D = 3;
  localparam int FILTERS_D  = 16;
  localparam int K_D        = 3;
  localparam int PAD_D      = 1;

  localparam int ACC_W   = 32;
  localparam int IMG_AW  = 10;
  localparam int KER_AW  = 9;
  localparam int BIAS_AW = 4;
  localparam int POS_W   = 5;
  localparam int TAP_W   = 2;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_BIAS  = 3'd1;
  localparam state_t S_MAC   = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_OUT   = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  function automatic logic [ACC_W-1:0] relu(
    input logic [ACC_W-1:0] v
  );
    return v[ACC_W-1] ? '0 : v;
  endfunction
endpackage

// File: rtl/conv2d_tap_gen.sv
// Tap walker for one output pixel: c/ky/kx counters, padding flag,
// and the image/kernel ROM addresses of the current tap.
module conv2d_tap_gen
  import conv2d_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int HEIGHT   = HEIGHT_D,
  parameter int CHANNELS = CHANNELS_D,
  parameter int K        = K_D,
  parameter int PAD      = PAD_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_adv,
  input  logic [BIAS_AW-1:0] i_f,
  input  logic [POS_W-1:0]   i_row,
  input  logic [POS_W-1:0]   i_col,
  output logic [TAP_W-1:0]   o_c,
  output logic               o_last,
  output logic               o_pad_ok,
  output logic [IMG_AW-1:0]  o_image_addr,
  output logic [KER_AW-1:0]  o_kernel_addr
);
  localparam int PW = POS_W + 2;

  logic [TAP_W-1:0] r_c;
  logic [TAP_W-1:0] r_ky;
  logic [TAP_W-1:0] r_kx;
  logic             w_kx_end;
  logic             w_ky_end;
  logic             w_c_end;
  logic [PW-1:0]    w_ry;
  logic [PW-1:0]    w_rx;
  logic [PW-1:0]    w_iy;
  logic [PW-1:0]    w_ix;
  logic             w_row_ok;
  logic             w_col_ok;
  logic [IMG_AW-1:0] w_iaddr;

  assign w_kx_end = (r_kx == TAP_W'(K - 1));
  assign w_ky_end = (r_ky == TAP_W'(K - 1));
  assign w_c_end  = (r_c == TAP_W'(CHANNELS - 1));

  // Step kx fastest, then ky, then channel; wrap to 0 after last tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c  <= '0;
      r_ky <= '0;
      r_kx <= '0;
    end else if (i_adv) begin
      if (w_kx_end) begin
        r_kx <= '0;
        if (w_ky_end) begin
          r_ky <= '0;
          r_c  <= w_c_end ? '0 : r_c + 1'b1;
        end else begin
          r_ky <= r_ky + 1'b1;
        end
      end else begin
        r_kx <= r_kx + 1'b1;
      end
    end
  end

  assign w_ry = PW'(i_row) + PW'(r_ky);
  assign w_rx = PW'(i_col) + PW'(r_kx);
  assign w_iy = w_ry - PW'(PAD);
  assign w_ix = w_rx - PW'(PAD);

  assign w_row_ok = (w_ry >= PW'(PAD)) &&
                    (w_ry < PW'(HEIGHT + PAD));
  assign w_col_ok = (w_rx >= PW'(PAD)) &&
                    (w_rx < PW'(WIDTH + PAD));

  assign w_iaddr = IMG_AW'(w_iy) * IMG_AW'(WIDTH) +
                   IMG_AW'(w_ix);

  assign o_c          = r_c;
  assign o_last       = w_kx_end & w_ky_end & w_c_end;
  assign o_pad_ok     = w_row_ok & w_col_ok;
  assign o_image_addr = o_pad_ok ? w_iaddr : '0;
  assign o_kernel_addr =
    KER_AW'(i_f) * KER_AW'(CHANNELS * K * K) +
    KER_AW'(r_c) * KER_AW'(K * K) +
    KER_AW'(r_ky) * KER_AW'(K) +
    KER_AW'(r_kx);
endmodule

// File: rtl/conv2d_mem_core.sv
// Streaming 3x3 conv engine fed from synchronous ROMs, filter-major out.
// Define CONV2D_RELU_EN to clamp negative results to 0.
module conv2d_mem_core
  import conv2d_pkg::*;
#(
  parameter int WIDTH              = WIDTH_D,
  parameter int HEIGHT             = HEIGHT_D,
  parameter int CHANNELS           = CHANNELS_D,
  parameter int FILTERS            = FILTERS_D,
  parameter int K                  = K_D,
  parameter int PAD                = PAD_D,
  parameter int BIAS_MODE_POST_ADD = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  output logic [IMG_AW-1:0]  image_addr,
  input  logic [7:0]         image_r_data,
  input  logic [7:0]         image_g_data,
  input  logic [7:0]         image_b_data,
  output logic [KER_AW-1:0]  kernel_addr,
  input  logic [7:0]         kernel_data,
  output logic [BIAS_AW-1:0] bias_addr,
  input  logic [7:0]         bias_data,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_valid
);
  state_t             r_state;
  logic               r_bcnt;
  logic [BIAS_AW-1:0] r_f;
  logic [POS_W-1:0]   r_row;
  logic [POS_W-1:0]   r_col;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_bias;
  logic               r_dv;
  logic [TAP_W-1:0]   r_dc;
  logic               r_done;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_out_valid;

  logic               w_adv;
  logic [TAP_W-1:0]   w_c;
  logic               w_last;
  logic               w_pad_ok;
  logic [7:0]         w_pix;
  logic [16:0]        w_pe;
  logic [16:0]        w_we;
  logic signed [16:0] w_prod;
  logic [ACC_W-1:0]   w_prod_sx;
  logic [ACC_W-1:0]   w_bias_sx;
  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_res;
  logic [ACC_W-1:0]   w_init;
  logic               w_col_end;
  logic               w_row_end;
  logic               w_f_end;
  logic               w_post;

  assign w_adv  = (r_state == S_MAC);
  assign w_post = (BIAS_MODE_POST_ADD != 0);

  conv2d_tap_gen #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .CHANNELS (CHANNELS),
    .K        (K),
    .PAD      (PAD)
  ) u_tap (
    .clk           (clk),
    .rst           (rst),
    .i_adv         (w_adv),
    .i_f           (r_f),
    .i_row         (r_row),
    .i_col         (r_col),
    .o_c           (w_c),
    .o_last        (w_last),
    .o_pad_ok      (w_pad_ok),
    .o_image_addr  (image_addr),
    .o_kernel_addr (kernel_addr)
  );

  // ROM data belongs to the tap issued last cycle: use delayed channel.
  always_comb begin
    w_pix = image_b_data;
    unique case (1'b1)
      (r_dc == 2'd0): w_pix = image_r_data;
      (r_dc == 2'd1): w_pix = image_g_data;
      default:        w_pix = image_b_data;
    endcase
  end

  assign w_pe      = {9'd0, w_pix};
  assign w_we      = {{9{kernel_data[7]}}, kernel_data};
  assign w_prod    = $signed(w_pe) * $signed(w_we);
  assign w_prod_sx = {{(ACC_W-17){w_prod[16]}}, w_prod};
  assign w_bias_sx = {{(ACC_W-8){bias_data[7]}}, bias_data};

  assign w_acc_next = r_acc + (r_dv ? w_prod_sx : '0);
  assign w_sum      = w_acc_next + (w_post ? r_bias : '0);
  assign w_init     = w_post ? '0 : r_bias;

`ifdef CONV2D_RELU_EN
  assign w_res = relu(w_sum);
`else
  assign w_res = w_sum;
`endif

  assign w_col_end = (r_col == POS_W'(WIDTH - 1));
  assign w_row_end = (r_row == POS_W'(HEIGHT - 1));
  assign w_f_end   = (r_f == BIAS_AW'(FILTERS - 1));

  // Sequencer: bias fetch, tap issue, drain, output, pixel advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= 1'b0;
      r_f     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_f     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_bcnt  <= 1'b0;
            r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          r_bcnt <= ~r_bcnt;
          if (r_bcnt) r_state <= S_MAC;
        end
        S_MAC: begin
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_OUT;
        S_OUT: begin
          if (!w_col_end) begin
            r_col   <= r_col + 1'b1;
            r_state <= S_MAC;
          end else begin
            r_col <= '0;
            if (!w_row_end) begin
              r_row   <= r_row + 1'b1;
              r_state <= S_MAC;
            end else begin
              r_row <= '0;
              if (w_f_end) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_f     <= r_f + 1'b1;
                r_bcnt  <= 1'b0;
                r_state <= S_BIAS;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MAC datapath: delayed tap tags, accumulator, result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dv        <= 1'b0;
      r_dc        <= '0;
      r_acc       <= '0;
      r_bias      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_dv        <= w_adv & w_pad_ok;
      r_dc        <= w_c;
      r_out_valid <= 1'b0;
      if (r_state == S_BIAS && r_bcnt) begin
        r_bias <= w_bias_sx;
        r_acc  <= w_post ? '0 : w_bias_sx;
      end else if (r_state == S_OUT) begin
        r_acc <= w_init;
      end else if (r_dv) begin
        r_acc <= w_acc_next;
      end
      if (r_state == S_DRAIN) begin
        r_out_data  <= w_res;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign done      = r_done;
  assign bias_addr = r_f;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_conv2d_mem_core.sv
// Scoreboard bench for conv2d_mem_core on a reduced 8x7x3-filter frame.
// Expected stream comes from a direct convolution model over the ROMs.
module tb_conv2d_mem_core;
  localparam int W     = 8;
  localparam int H     = 7;
  localparam int F     = 3;
  localparam int NPIX  = W * H;
  localparam int TOTAL = F * NPIX;
  localparam int LIMIT = 6000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic [9:0]  image_addr;
  logic [7:0]  image_r_data;
  logic [7:0]  image_g_data;
  logic [7:0]  image_b_data;
  logic [8:0]  kernel_addr;
  logic [7:0]  kernel_data;
  logic [3:0]  bias_addr;
  logic [7:0]  bias_data;
  logic [31:0] out_data;
  logic        out_valid;

  logic [7:0] img_r [1024];
  logic [7:0] img_g [1024];
  logic [7:0] img_b [1024];
  logic [7:0] ker   [512];
  logic [7:0] bia   [16];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          nstrobe = 0;
  logic [31:0] q [$];
  logic [31:0] cap [TOTAL];

  conv2d_mem_core #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .FILTERS (F)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (done),
    .image_addr   (image_addr),
    .image_r_data (image_r_data),
    .image_g_data (image_g_data),
    .image_b_data (image_b_data),
    .kernel_addr  (kernel_addr),
    .kernel_data  (kernel_data),
    .bias_addr    (bias_addr),
    .bias_data    (bias_data),
    .out_data     (out_data),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    image_r_data <= img_r[image_addr];
    image_g_data <= img_g[image_addr];
    image_b_data <= img_b[image_addr];
    kernel_data  <= ker[kernel_addr];
    bias_data    <= bia[bias_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int f, input int r,
                                        input int c);
    int s;
    int iy;
    int ix;
    int p;
    s = int'($signed(bia[f]));
    for (int ch = 0; ch < 3; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          iy = r + ky - 1;
          ix = c + kx - 1;
          if (iy >= 0 && iy < H && ix >= 0 && ix < W) begin
            p = (ch == 0) ? int'(img_r[iy*W+ix]) :
                (ch == 1) ? int'(img_g[iy*W+ix]) :
                            int'(img_b[iy*W+ix]);
            s += p * int'($signed(ker[f*27+ch*9+ky*3+kx]));
          end
        end
`ifdef CONV2D_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic push_all();
    q.delete();
    for (int f = 0; f < F; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          q.push_back(model(f, r, c));
    nstrobe = 0;
  endtask

  task automatic set_all(input logic [7:0] kv, input logic [7:0] bv,
                         input logic [7:0] pv);
    for (int i = 0; i < 1024; i++) begin
      img_r[i] = pv;
      img_g[i] = pv;
      img_b[i] = pv;
    end
    for (int i = 0; i < 512; i++) ker[i] = kv;
    for (int i = 0; i < 16; i++) bia[i] = bv;
  endtask

  task automatic run(input bit restart_mid);
    push_all();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < LIMIT && !done; k++) begin
      @(negedge clk);
      if (restart_mid && k == 700) begin
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
    end
    chk("done_set", {31'd0, done}, 32'd1);
    chk("strobe_count", nstrobe, TOTAL);
    chk("queue_empty", q.size(), 0);
    chk("valid_in_done", {31'd0, out_valid}, 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL strobe: unexpected out_data=%0h expected none",
               out_data);
      end else begin
        chk("out_data", out_data, q.pop_front());
      end
      chk("done_during_run", {31'd0, done}, 32'd0);
      if (nstrobe > 0 && nstrobe % NPIX != 0)
        chk("spacing", cyc - last_cyc, 29);
      else if (nstrobe > 0)
        chk("filter_gap", cyc - last_cyc, 31);
      if (nstrobe < TOTAL) cap[nstrobe] = out_data;
      last_cyc = cyc;
      nstrobe++;
    end
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    set_all(8'd0, 8'd0, 8'd0);
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_iaddr", {22'd0, image_addr}, 32'd0);
    chk("rst_kaddr", {23'd0, kernel_addr}, 32'd0);
    chk("rst_baddr", {28'd0, bias_addr}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    set_all(8'd0, 8'd5, 8'd0);
    for (int i = 0; i < NPIX; i++) begin
      img_r[i] = 8'($urandom);
      img_g[i] = 8'($urandom);
      img_b[i] = 8'($urandom);
    end
    run(1'b0);
    chk("bias5_first", cap[0], 32'd5);
    chk("bias5_last", cap[TOTAL-1], 32'd5);

    set_all(8'd1, 8'd0, 8'd1);
    run(1'b0);
    chk("ones_c00", cap[0], 32'd12);
    chk("ones_c0r", cap[W-1], 32'd12);
    chk("ones_cb0", cap[(H-1)*W], 32'd12);
    chk("ones_cbr", cap[NPIX-1], 32'd12);
    chk("ones_top", cap[5], 32'd18);
    chk("ones_left", cap[3*W], 32'd18);
    chk("ones_right", cap[3*W+W-1], 32'd18);
    chk("ones_bot", cap[(H-1)*W+3], 32'd18);
    chk("ones_int", cap[5*W+5], 32'd27);

    set_all(8'd0, 8'd0, 8'd0);
    ker[13 - 9] = 8'd1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_r[r*W+c] = 8'((r*32 + c) % 256);
        img_g[r*W+c] = 8'($urandom);
        img_b[r*W+c] = 8'($urandom);
      end
    run(1'b0);
    chk("id_px_2_3", cap[2*W+3], 32'(2*32+3));
    chk("id_px_6_7", cap[6*W+7], 32'(6*32+7));
    for (int i = 0; i < NPIX; i++) begin
      img_g[i] = 8'($urandom);
      img_b[i] = 8'($urandom);
    end
    run(1'b0);
    chk("id_gb_0_0", cap[0], 32'd0);
    chk("id_gb_4_1", cap[4*W+1], 32'(4*32+1));

    set_all(8'hFF, 8'hFD, 8'hFF);
    run(1'b0);
`ifdef CONV2D_RELU_EN
    chk("neg_int", cap[2*W+2], 32'd0);
`else
    chk("neg_int", cap[2*W+2], 32'hFFFFE518);
`endif

    set_all(8'd0, 8'd0, 8'd0);
    for (int f = 0; f < F; f++) bia[f] = 8'(f);
    run(1'b1);
    for (int f = 0; f < F; f++) begin
      chk("fblk_first", cap[f*NPIX], 32'(f));
      chk("fblk_last", cap[f*NPIX+NPIX-1], 32'(f));
    end

    push_all();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    begin
      int k;
      for (k = 0; k < LIMIT && !(out_valid && nstrobe > 20); k++)
        @(negedge clk);
      chk("mid_strobe_seen", {31'd0, k < LIMIT}, 32'd1);
    end
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_quiet", {31'd0, done}, 32'd0);
    run(1'b0);
    chk("rerun_last", cap[TOTAL-1], 32'(F-1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv2d_mem_core.md
Name: conv2d_mem_core

Overview:
- Streaming 2-D convolution engine for the first CIFAR-10 conv layer: 32x32 RGB, 8-bit fixed-point inputs, 16 filters of 3x3, zero padding 1, stride 1, same-size output.
- Fetches image, kernel and bias values from external synchronous ROMs.
- Emits one 32-bit result per output pixel on a valid strobe, filter-major. Sits between the weight/image ROMs and the feature-map sink.

Parameters:
- WIDTH, 32, image columns.
- HEIGHT, 32, image rows.
- CHANNELS, 3, input channels (R, G, B).
- FILTERS, 16, output filters.
- K, 3, kernel side.
- PAD, 1, zero-padding border.
- BIAS_MODE_POST_ADD, 1: 1 = bias added after the 27-term sum; 0 = accumulator preloaded with bias. Results are identical in both modes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full run.
- done  out  1  high after the last output; held until the next accepted start.
- image_addr  out  10  row*WIDTH+col.
- image_r_data, image_g_data, image_b_data  in  8 each  unsigned pixels; 1-cycle synchronous ROM latency.
- kernel_addr  out  9  f*27 + c*9 + ky*3 + kx; c order is R=0, G=1, B=2.
- kernel_data  in  8  signed weight.
- bias_addr  out  4  filter index.
- bias_data  in  8  signed bias.
- out_data  out  32  signed sum (two's complement).
- out_valid  out  1  one-cycle strobe per result.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; done=0, out_valid=0, out_data=0, all addresses 0.
- IDLE: start=1 clears done, sets f=row=col=0, goes to BIAS. start is ignored in every state other than IDLE/DONE.
- BIAS (2 cycles): drive bias_addr=f; capture the sign-extended bias on the second cycle. Entered once per filter.
- MAC (27 issue cycles per pixel), loop order c outer, ky, kx inner:
  - Drive image_addr and kernel_addr each cycle.
  - Data returns next cycle; select R/G/B by the delayed c.
  - Product = $signed({1'b0,pixel}) * $signed(weight), sign-extended to 32 bits and accumulated.
- Padding: tap with row+ky-PAD or col+kx-PAD outside [0, dim-1] contributes exactly 0. Address driven as 0 in that case, data ignored.
- DRAIN (1 cycle): absorb the last ROM return.
- OUT (1 cycle): out_data = acc (+ bias in post-add mode), out_valid=1.
- Pixel period is exactly 29 cycles (27+1+1). Each filter adds 2 BIAS cycles before its first pixel.
- Advance: col++; col wraps to 0 with row++; row wraps with f++ and return to BIAS; after f=FILTERS-1, row=HEIGHT-1, col=WIDTH-1 go to DONE.
- Output order: filter 0 rows 0..31 cols 0..31, then filter 1, and so on; 16384 strobes total.
- DONE: done=1, out_valid=0; start restarts the run.
- Accumulator is 32-bit with wrap-around; no saturation.
- out_data holds its last value between strobes.
- Reset mid-run aborts immediately to IDLE with no further strobes.

Optional Feature:
- CONV2D_RELU_EN defined: at OUT, negative results are replaced by 0.
- Undefined: raw signed sum is output.
- Timing is identical in both cases.

Decomposition:
- Package conv2d_pkg: state enum (IDLE, BIAS, MAC, DRAIN, OUT, DONE), default dimensions, address-width localparams, ACC_W=32.
- One sub-module: conv2d_tap_gen. Generates c/ky/kx counters, the padding-valid flag and the image/kernel addresses for the current (f,row,col).
- The MAC datapath and FSM stay in the top module.

Test Plan:
- All kernels 0, all biases 5, any image -> all 16384 outputs = 5; done rises after the last strobe; strobes spaced exactly 29 cycles within a filter.
- All pixels 1, all weights 1, bias 0:
  - corner (0,0) = 12; edge (0,5) = 18; interior (5,5) = 27.
  - Verifies padding at all four borders.
- Filter 0: center R weight 1, all else 0; image R = (row*32+col) mod 256 -> output equals the R pixel; G/B changes have no effect.
- All weights -1, pixels 255, bias -3 -> interior -6888 (0xFFFFE518).
  - With CONV2D_RELU_EN: 0.
- start pulsed again mid-run -> ignored, stream unchanged; rst low mid-run -> out_valid and done 0 immediately; a fresh start reproduces the full stream.
- Bias per filter = f, kernels 0 -> filter f block is constant f; exactly 1024 strobes per filter in filter order.
